mano_control_unit: RTL and testbench
====================================

# mano_control_unit

Timing and control unit for the Mano basic computer: a 4-bit sequence counter plus instruction decode that drives the 3-bit select of the common 16-bit bus and every register/memory strobe. It sits directly upstream of the bus multiplexer and the register file. It consumes IR and datapath status flags and sequences fetch, indirect, and execute for all memory-reference and register-reference instructions. I/O instructions execute as NOP; interrupts are not implemented.

## Interface
- No parameters; widths are fixed by the architecture (16-bit word, 12-bit address).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; sets S (run) when halted
- ir  in  16  current IR contents (IR[15]=I, IR[14:12]=opcode, IR[11:0]=address/op bits)
- ac_zero  in  1  AC == 0
- ac_sign  in  1  AC[15]
- dr_zero  in  1  DR == 0
- e_flag  in  1  E flip-flop
- bus_sel  out  3  bus source: 0 none (Z), 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 memory
- ld_ar, inc_ar  out  1 each  AR load / increment
- ld_pc, inc_pc  out  1 each  PC load / increment
- ld_dr, inc_dr  out  1 each  DR load / increment
- ld_ac, inc_ac, clr_ac  out  1 each  AC load (from ALU) / increment / clear
- alu_op  out  3  ALU function presented to AC input
- ld_ir  out  1  IR load
- mem_rd, mem_wr  out  1 each  memory read / write at M[AR]
- clr_e, cmp_e  out  1 each  E clear / complement
- sc  out  4  sequence counter value (T-state index)
- running  out  1  S flip-flop

## Operation
- State: SC (4 bits), I (1 bit, latched from ir[15] at end of T2), S (run). Opcode decoded combinationally from ir[14:12] (D0–D7).
- All outputs are combinational from SC, I, S, ir, and status inputs; they take effect in the datapath on the next rising edge. Default: bus_sel=0, all strobes 0, alu_op=NOP.
- S=0: SC held at 0, all outputs at default. start while S=0 sets S at next edge; start while S=1 is ignored.
- Fetch: T0 bus_sel=PC, ld_ar. T1 bus_sel=MEM, mem_rd, ld_ir, inc_pc. T2 bus_sel=IR, ld_ar; I<=ir[15].
- T3: D7'·I: bus_sel=MEM, mem_rd, ld_ar (indirect). D7'·I': no strobes. D7·I': register-reference execute, SC<=0. D7·I: NOP, SC<=0.
- AND/ADD/LDA (D0/D1/D2): T4 bus_sel=MEM, mem_rd, ld_dr. T5 ld_ac with alu_op=AND/ADD/XFER_DR, SC<=0 (ADD carry into E handled by the ALU).
- STA (D3): T4 bus_sel=AC, mem_wr, SC<=0.
- BUN (D4): T4 bus_sel=AR, ld_pc, SC<=0.
- BSA (D5): T4 bus_sel=PC, mem_wr, inc_ar. T5 bus_sel=AR, ld_pc, SC<=0.
- ISZ (D6): T4 bus_sel=MEM, mem_rd, ld_dr. T5 inc_dr. T6 bus_sel=DR, mem_wr; inc_pc if dr_zero; SC<=0.
- Register-reference (bits ir[11:0], several may be set simultaneously; all selected actions issue in T3): b11 CLA→clr_ac; b10 CLE→clr_e; b9 CMA, b7 CIR, b6 CIL→ld_ac with alu_op; when several of these are set, priority is CMA > CIR > CIL; b8 CME→cmp_e; b5 INC→inc_ac; skip-condition bits b4 SPA (!ac_sign), b3 SNA (ac_sign), b2 SZA (ac_zero), b1 SZE (!e_flag) are ORed into a single inc_pc; b0 HLT→S<=0.
- An instruction that is not terminated by the rules above advances SC by 1 per cycle. SC never exceeds 6.

## Timing
- Reset (asynchronous assert, synchronous-safe release): SC=0, I=0, S=1; execution starts with T0 at the first edge after release. All outputs are at default except those T0 decodes to (bus_sel=2, ld_ar=1).
- Cycles per instruction: register-ref/I/O 4; STA, BUN 5; AND, ADD, LDA, BSA 6; ISZ 7. Indirect addressing adds no cycles.
- HLT: S clears at the end of T3; the following cycle shows running=0 and SC=0.
- Reset mid-instruction aborts it immediately; no strobe is asserted while rst_n=0.

## Structure
- Package mano_pkg: BUS_* select constants (0–7), ALU_* encodings (NOP, AND, ADD, XFER_DR, CMA, CIR, CIL), OP_* opcode constants, and register-reference bit indices.
- Sub-module mano_seq_counter: 4-bit counter with async clear, synchronous clr, and inc.

## Test plan
- Reset then release with ir=0x2010 (LDA 0x010, direct) -> T0..T5 sequence; T1 has bus_sel=7/mem_rd/ld_ir/inc_pc; T5 has ld_ac and alu_op=XFER_DR; SC returns to 0 after 6 cycles.
- ir=0x9020 (ADD indirect) -> T3 has bus_sel=7, mem_rd, ld_ar; T5 has alu_op=ADD; 6 cycles total.
- ir=0x6030 (ISZ) with dr_zero=1 at T6 -> bus_sel=3, mem_wr, inc_pc in T6; repeat with dr_zero=0 -> no inc_pc.
- ir=0x7A20 (CLA|CMA|INC) -> in T3: clr_ac, ld_ac with alu_op=CMA, inc_ac; ir=0x7014 (SPA|SZA) with ac_sign=1, ac_zero=1 -> inc_pc=1.
- ir=0x7001 (HLT) -> running=0 after T3; outputs at default for 10 cycles; start pulse -> T0 outputs on the next cycle.
- Assert rst_n=0 during ISZ T5 -> SC=0 and all strobes 0 immediately; after release, fetch restarts at T0.

Source files
------------

// File: rtl/mano_pkg.sv
// Shared constants for the Mano basic computer control unit: bus sources,
// ALU function codes, opcodes and register-reference bit positions.
package mano_pkg;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_TR   = 3'd6;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  localparam logic [2:0] ALU_NOP     = 3'd0;
  localparam logic [2:0] ALU_AND     = 3'd1;
  localparam logic [2:0] ALU_ADD     = 3'd2;
  localparam logic [2:0] ALU_XFER_DR = 3'd3;
  localparam logic [2:0] ALU_CMA     = 3'd4;
  localparam logic [2:0] ALU_CIR     = 3'd5;
  localparam logic [2:0] ALU_CIL     = 3'd6;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  localparam int RB_CLA = 11;
  localparam int RB_CLE = 10;
  localparam int RB_CMA = 9;
  localparam int RB_CME = 8;
  localparam int RB_CIR = 7;
  localparam int RB_CIL = 6;
  localparam int RB_INC = 5;
  localparam int RB_SPA = 4;
  localparam int RB_SNA = 3;
  localparam int RB_SZA = 2;
  localparam int RB_SZE = 1;
  localparam int RB_HLT = 0;

  typedef enum logic [3:0] {
    T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3,
    T4 = 4'd4, T5 = 4'd5, T6 = 4'd6
  } tstate_t;

endpackage

// File: rtl/mano_seq_counter.sv
// 4-bit T-state sequence counter; synchronous clear wins over increment.
module mano_seq_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= 4'd0;
    else if (clr)
      count <= 4'd0;
    else if (inc)
      count <= count + 4'd1;
  end

endmodule

// File: rtl/mano_control_unit.sv
// Timing and control unit for the Mano basic computer: sequences fetch,
// indirect and execute, and decodes the bus select and register strobes.
module mano_control_unit
  import mano_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] ir,
  input  logic        ac_zero,
  input  logic        ac_sign,
  input  logic        dr_zero,
  input  logic        e_flag,
  output logic [2:0]  bus_sel,
  output logic        ld_ar,
  output logic        inc_ar,
  output logic        ld_pc,
  output logic        inc_pc,
  output logic        ld_dr,
  output logic        inc_dr,
  output logic        ld_ac,
  output logic        inc_ac,
  output logic        clr_ac,
  output logic [2:0]  alu_op,
  output logic        ld_ir,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        clr_e,
  output logic        cmp_e,
  output logic [3:0]  sc,
  output logic        running
);

  logic       s_reg;
  logic       i_reg;
  logic       sc_clr;
  logic       sc_inc;
  logic       halt;
  logic [2:0] opcode;
  logic       skip;

  assign opcode  = ir[14:12];
  assign running = s_reg;
  assign skip = (ir[RB_SPA] & ~ac_sign) | (ir[RB_SNA] & ac_sign) |
                (ir[RB_SZA] & ac_zero)  | (ir[RB_SZE] & ~e_flag);

  mano_seq_counter u_seq_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sc_clr),
    .inc   (sc_inc),
    .count (sc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg <= 1'b1;
      i_reg <= 1'b0;
    end else begin
      if (!s_reg && start)
        s_reg <= 1'b1;
      else if (halt)
        s_reg <= 1'b0;
      if (s_reg && sc == T2)
        i_reg <= ir[15];
    end
  end

  // Outputs are gated by rst_n so nothing strobes while reset is held.
  always_comb begin
    bus_sel = BUS_NONE;
    ld_ar   = 1'b0;
    inc_ar  = 1'b0;
    ld_pc   = 1'b0;
    inc_pc  = 1'b0;
    ld_dr   = 1'b0;
    inc_dr  = 1'b0;
    ld_ac   = 1'b0;
    inc_ac  = 1'b0;
    clr_ac  = 1'b0;
    alu_op  = ALU_NOP;
    ld_ir   = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    clr_e   = 1'b0;
    cmp_e   = 1'b0;
    sc_clr  = 1'b0;
    sc_inc  = 1'b0;
    halt    = 1'b0;
    if (!s_reg) begin
      sc_clr = 1'b1;
    end else if (rst_n) begin
      sc_inc = 1'b1;
      case (sc)
        T0: begin
          bus_sel = BUS_PC;
          ld_ar   = 1'b1;
        end
        T1: begin
          bus_sel = BUS_MEM;
          mem_rd  = 1'b1;
          ld_ir   = 1'b1;
          inc_pc  = 1'b1;
        end
        T2: begin
          bus_sel = BUS_IR;
          ld_ar   = 1'b1;
        end
        T3: begin
          if (opcode != OP_REG) begin
            if (i_reg) begin
              bus_sel = BUS_MEM;
              mem_rd  = 1'b1;
              ld_ar   = 1'b1;
            end
          end else begin
            sc_clr = 1'b1;
            if (!i_reg) begin
              clr_ac = ir[RB_CLA];
              clr_e  = ir[RB_CLE];
              cmp_e  = ir[RB_CME];
              inc_ac = ir[RB_INC];
              inc_pc = skip;
              halt   = ir[RB_HLT];
              if (ir[RB_CMA] | ir[RB_CIR] | ir[RB_CIL]) begin
                ld_ac = 1'b1;
                if (ir[RB_CMA])      alu_op = ALU_CMA;
                else if (ir[RB_CIR]) alu_op = ALU_CIR;
                else                 alu_op = ALU_CIL;
              end
            end
          end
        end
        T4: begin
          case (opcode)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
              bus_sel = BUS_MEM;
              mem_rd  = 1'b1;
              ld_dr   = 1'b1;
            end
            OP_STA: begin
              bus_sel = BUS_AC;
              mem_wr  = 1'b1;
              sc_clr  = 1'b1;
            end
            OP_BUN: begin
              bus_sel = BUS_AR;
              ld_pc   = 1'b1;
              sc_clr  = 1'b1;
            end
            OP_BSA: begin
              bus_sel = BUS_PC;
              mem_wr  = 1'b1;
              inc_ar  = 1'b1;
            end
            default: sc_clr = 1'b1;
          endcase
        end
        T5: begin
          case (opcode)
            OP_AND: begin ld_ac = 1'b1; alu_op = ALU_AND;     sc_clr = 1'b1; end
            OP_ADD: begin ld_ac = 1'b1; alu_op = ALU_ADD;     sc_clr = 1'b1; end
            OP_LDA: begin ld_ac = 1'b1; alu_op = ALU_XFER_DR; sc_clr = 1'b1; end
            OP_BSA: begin
              bus_sel = BUS_AR;
              ld_pc   = 1'b1;
              sc_clr  = 1'b1;
            end
            OP_ISZ:  inc_dr = 1'b1;
            default: sc_clr = 1'b1;
          endcase
        end
        T6: begin
          sc_clr = 1'b1;
          if (opcode == OP_ISZ) begin
            bus_sel = BUS_DR;
            mem_wr  = 1'b1;
            inc_pc  = dr_zero;
          end
        end
        default: sc_clr = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_mano_control_unit.sv
// Directed self-checking bench for mano_control_unit with hand-computed
// strobe patterns for each T-state.
module tb_mano_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] ir;
  logic        ac_zero, ac_sign, dr_zero, e_flag;
  logic [2:0]  bus_sel, alu_op;
  logic        ld_ar, inc_ar, ld_pc, inc_pc, ld_dr, inc_dr;
  logic        ld_ac, inc_ac, clr_ac, ld_ir, mem_rd, mem_wr, clr_e, cmp_e;
  logic [3:0]  sc;
  logic        running;
  logic [19:0] ctrl;

  int checkCount = 0;
  int errorCount = 0;

  localparam logic [19:0] C_LD_AR  = 20'h10000;
  localparam logic [19:0] C_INC_AR = 20'h08000;
  localparam logic [19:0] C_LD_PC  = 20'h04000;
  localparam logic [19:0] C_INC_PC = 20'h02000;
  localparam logic [19:0] C_LD_DR  = 20'h01000;
  localparam logic [19:0] C_INC_DR = 20'h00800;
  localparam logic [19:0] C_LD_AC  = 20'h00400;
  localparam logic [19:0] C_INC_AC = 20'h00200;
  localparam logic [19:0] C_CLR_AC = 20'h00100;
  localparam logic [19:0] C_LD_IR  = 20'h00010;
  localparam logic [19:0] C_MEM_RD = 20'h00008;
  localparam logic [19:0] C_MEM_WR = 20'h00004;
  localparam logic [19:0] C_CLR_E  = 20'h00002;
  localparam logic [19:0] C_CMP_E  = 20'h00001;

  always #5 clk = ~clk;

  mano_control_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ir(ir),
    .ac_zero(ac_zero), .ac_sign(ac_sign), .dr_zero(dr_zero), .e_flag(e_flag),
    .bus_sel(bus_sel), .ld_ar(ld_ar), .inc_ar(inc_ar), .ld_pc(ld_pc),
    .inc_pc(inc_pc), .ld_dr(ld_dr), .inc_dr(inc_dr), .ld_ac(ld_ac),
    .inc_ac(inc_ac), .clr_ac(clr_ac), .alu_op(alu_op), .ld_ir(ld_ir),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .clr_e(clr_e), .cmp_e(cmp_e),
    .sc(sc), .running(running)
  );

  assign ctrl = {bus_sel, ld_ar, inc_ar, ld_pc, inc_pc, ld_dr, inc_dr,
                 ld_ac, inc_ac, clr_ac, alu_op, ld_ir, mem_rd, mem_wr,
                 clr_e, cmp_e};

  function automatic logic [19:0] busf(input logic [2:0] b);
    return {b, 17'b0};
  endfunction

  function automatic logic [19:0] aluf(input logic [2:0] a);
    return {12'b0, a, 5'b0};
  endfunction

  task automatic checkOutput(input string tag, input logic [24:0] actual,
                             input logic [24:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] instr, input logic az,
                               input logic as, input logic dz, input logic e);
    ir = instr; ac_zero = az; ac_sign = as; dr_zero = dz; e_flag = e;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  // Checks the current running T-state, then advances one clock.
  task automatic checkCycle(input string tag, input logic [3:0] exp_sc,
                            input logic [19:0] exp_ctrl);
    checkOutput(tag, {sc, running, ctrl}, {exp_sc, 1'b1, exp_ctrl});
    nextCycle();
  endtask

  task automatic checkFetch(input string tag);
    checkCycle({tag, "_t0"}, 4'd0, busf(3'd2) | C_LD_AR);
    checkCycle({tag, "_t1"}, 4'd1, busf(3'd7) | C_MEM_RD | C_LD_IR | C_INC_PC);
    checkCycle({tag, "_t2"}, 4'd2, busf(3'd5) | C_LD_AR);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    applyStimulus(16'h2010, 1'b0, 1'b0, 1'b0, 1'b1);
    #12;
    checkOutput("reset", {sc, running, ctrl}, {4'd0, 1'b1, 20'h0});
    rst_n = 1'b1;
    #1;

    checkFetch("lda");
    checkCycle("lda_t3", 4'd3, 20'h0);
    checkCycle("lda_t4", 4'd4, busf(3'd7) | C_MEM_RD | C_LD_DR);
    checkCycle("lda_t5", 4'd5, C_LD_AC | aluf(3'd3));

    applyStimulus(16'h9020, 1'b0, 1'b0, 1'b0, 1'b1);
    checkFetch("addi");
    checkCycle("addi_t3", 4'd3, busf(3'd7) | C_MEM_RD | C_LD_AR);
    checkCycle("addi_t4", 4'd4, busf(3'd7) | C_MEM_RD | C_LD_DR);
    checkCycle("addi_t5", 4'd5, C_LD_AC | aluf(3'd2));

    applyStimulus(16'h0070, 1'b0, 1'b0, 1'b0, 1'b1);
    checkFetch("and");
    checkCycle("and_t3", 4'd3, 20'h0);
    checkCycle("and_t4", 4'd4, busf(3'd7) | C_MEM_RD | C_LD_DR);
    checkCycle("and_t5", 4'd5, C_LD_AC | aluf(3'd1));

    applyStimulus(16'h6030, 1'b0, 1'b0, 1'b1, 1'b1);
    checkFetch("isz1");
    checkCycle("isz1_t3", 4'd3, 20'h0);
    checkCycle("isz1_t4", 4'd4, busf(3'd7) | C_MEM_RD | C_LD_DR);
    checkCycle("isz1_t5", 4'd5, C_INC_DR);
    checkCycle("isz1_t6", 4'd6, busf(3'd3) | C_MEM_WR | C_INC_PC);

    applyStimulus(16'h6030, 1'b0, 1'b0, 1'b0, 1'b1);
    checkFetch("isz0");
    checkCycle("isz0_t3", 4'd3, 20'h0);
    checkCycle("isz0_t4", 4'd4, busf(3'd7) | C_MEM_RD | C_LD_DR);
    checkCycle("isz0_t5", 4'd5, C_INC_DR);
    checkCycle("isz0_t6", 4'd6, busf(3'd3) | C_MEM_WR);

    applyStimulus(16'h3040, 1'b0, 1'b0, 1'b0, 1'b1);
    checkFetch("sta");
    checkCycle("sta_t3", 4'd3, 20'h0);
    checkCycle("sta_t4", 4'd4, busf(3'd4) | C_MEM_WR);

    applyStimulus(16'h4050, 1'b0, 1'b0, 1'b0, 1'b1);
    checkFetch("bun");
    checkCycle("bun_t3", 4'd3, 20'h0);
    checkCycle("bun_t4", 4'd4, busf(3'd1) | C_LD_PC);

    applyStimulus(16'h5060, 1'b0, 1'b0, 1'b0, 1'b1);
    checkFetch("bsa");
    checkCycle("bsa_t3", 4'd3, 20'h0);
    checkCycle("bsa_t4", 4'd4, busf(3'd2) | C_MEM_WR | C_INC_AR);
    checkCycle("bsa_t5", 4'd5, busf(3'd1) | C_LD_PC);

    applyStimulus(16'h7A20, 1'b0, 1'b0, 1'b0, 1'b1);
    checkFetch("cla_cma_inc");
    checkCycle("cla_cma_inc_t3", 4'd3, C_CLR_AC | C_LD_AC | aluf(3'd4) | C_INC_AC);

    applyStimulus(16'h7014, 1'b1, 1'b1, 1'b0, 1'b1);
    checkFetch("spa_sza");
    checkCycle("spa_sza_t3", 4'd3, C_INC_PC);

    applyStimulus(16'h7014, 1'b0, 1'b1, 1'b0, 1'b1);
    checkFetch("spa_sza_noskip");
    checkCycle("spa_sza_noskip_t3", 4'd3, 20'h0);

    applyStimulus(16'h70C0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkFetch("cir_cil");
    checkCycle("cir_cil_t3", 4'd3, C_LD_AC | aluf(3'd5));

    applyStimulus(16'h7502, 1'b0, 1'b0, 1'b0, 1'b0);
    checkFetch("cle_cme_sze");
    checkCycle("cle_cme_sze_t3", 4'd3, C_CLR_E | C_CMP_E | C_INC_PC);

    applyStimulus(16'hF800, 1'b0, 1'b0, 1'b0, 1'b1);
    checkFetch("io_nop");
    checkCycle("io_nop_t3", 4'd3, 20'h0);

    applyStimulus(16'h7001, 1'b0, 1'b0, 1'b0, 1'b1);
    checkFetch("hlt");
    checkCycle("hlt_t3", 4'd3, 20'h0);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("halted_%0d", i), {sc, running, ctrl}, {4'd0, 1'b0, 20'h0});
      nextCycle();
    end
    start = 1'b1;
    nextCycle();
    start = 1'b0;
    checkOutput("restart_t0", {sc, running, ctrl},
                {4'd0, 1'b1, busf(3'd2) | C_LD_AR});

    applyStimulus(16'h6030, 1'b0, 1'b0, 1'b1, 1'b1);
    checkFetch("iszr");
    checkCycle("iszr_t3", 4'd3, 20'h0);
    checkCycle("iszr_t4", 4'd4, busf(3'd7) | C_MEM_RD | C_LD_DR);
    checkOutput("iszr_t5", {sc, running, ctrl}, {4'd5, 1'b1, C_INC_DR});
    rst_n = 1'b0;
    #1;
    checkOutput("midreset", {sc, running, ctrl}, {4'd0, 1'b1, 20'h0});
    nextCycle();
    checkOutput("midreset_hold", {sc, running, ctrl}, {4'd0, 1'b1, 20'h0});
    rst_n = 1'b1;
    #1;
    checkFetch("after_reset");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
